// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, pipelined req/gnt/rvalid bus master and in-order instruction queue.
// Optional IFETCH_PERF_CNT_EN adds a saturating bubble counter output (bubble_cnt_o).
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module if_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  ibus_req_o,
    output logic [ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] ibus_rdata_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    output logic                  fetch_busy_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]           bubble_cnt_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]        DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(`NOP);

    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;

    // Address queue: addresses granted on the bus, awaiting their response.
    logic [ADDR_WIDTH-1:0] aq_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      aq_wr_reg, aq_wr_next;
    logic [PTR_W-1:0]      aq_rd_reg, aq_rd_next;
    logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]      kill_reg, kill_next;

    // Instruction queue of {addr, data} pairs presented to IF/ID.
    logic [ADDR_WIDTH-1:0] iq_addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] iq_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      iq_wr_reg, iq_wr_next;
    logic [PTR_W-1:0]      iq_rd_reg, iq_rd_next;
    logic [CNT_W-1:0]      inst_count_reg, inst_count_next;

    logic credit_ok;
    logic grant;
    logic resp;
    logic keep;
    logic pop;
    logic head_valid;
    logic jump_low_unused;

    assign jump_low_unused = ^jump_addr_i[1:0];

    // Killed responses still occupy credit until they return, so the queue can never overflow.
    assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, inst_count_reg}) < DEPTH_C;
    assign ibus_req_o = rst_i & ~flush_i & credit_ok;
    assign grant      = ibus_req_o & ibus_gnt_i;
    assign resp       = ibus_rvalid_i & (outstanding_reg != '0);
    assign keep       = resp & (kill_reg == '0) & ~flush_i;
    assign head_valid = inst_count_reg != '0;
    assign pop        = head_valid & ~stall_i & ~flush_i;

    always_comb begin
        pc_next          = pc_reg;
        aq_wr_next       = aq_wr_reg;
        aq_rd_next       = aq_rd_reg;
        outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(resp);
        kill_next        = kill_reg;
        iq_wr_next       = iq_wr_reg;
        iq_rd_next       = iq_rd_reg;
        inst_count_next  = inst_count_reg;

        if (grant) aq_wr_next = aq_wr_reg + PTR_W'(1);
        if (resp)  aq_rd_next = aq_rd_reg + PTR_W'(1);

        if (flush_i) begin
            pc_next         = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
            kill_next       = outstanding_reg - CNT_W'(resp);
            iq_wr_next      = '0;
            iq_rd_next      = '0;
            inst_count_next = '0;
        end else begin
            if (grant) pc_next = pc_reg + ADDR_WIDTH'(4);
            if (resp && kill_reg != '0) kill_next = kill_reg - CNT_W'(1);
            if (keep) iq_wr_next = iq_wr_reg + PTR_W'(1);
            if (pop)  iq_rd_next = iq_rd_reg + PTR_W'(1);
            inst_count_next = inst_count_reg + CNT_W'(keep) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_reg          <= RESET_PC;
            aq_wr_reg       <= '0;
            aq_rd_reg       <= '0;
            outstanding_reg <= '0;
            kill_reg        <= '0;
            iq_wr_reg       <= '0;
            iq_rd_reg       <= '0;
            inst_count_reg  <= '0;
        end else begin
            pc_reg          <= pc_next;
            aq_wr_reg       <= aq_wr_next;
            aq_rd_reg       <= aq_rd_next;
            outstanding_reg <= outstanding_next;
            kill_reg        <= kill_next;
            iq_wr_reg       <= iq_wr_next;
            iq_rd_reg       <= iq_rd_next;
            inst_count_reg  <= inst_count_next;
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk_i) begin
        if (grant) aq_mem[aq_wr_reg] <= pc_reg;
        if (keep) begin
            iq_addr_mem[iq_wr_reg] <= aq_mem[aq_rd_reg];
            iq_data_mem[iq_wr_reg] <= ibus_rdata_i;
        end
    end

    assign ibus_addr_o  = pc_reg;
    assign inst_valid_o = head_valid;
    assign fetch_busy_o = ~head_valid;
    assign inst_o       = head_valid ? iq_data_mem[iq_rd_reg] : NOP_WORD;
    assign inst_addr_o  = head_valid ? iq_addr_mem[iq_rd_reg] : '0;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] bubble_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_reg <= '0;
        end else if (!head_valid && !stall_i && bubble_reg != 32'hFFFF_FFFF) begin
            bubble_reg <= bubble_reg + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_reg;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed table, corner-case sequences and a random bus
// checked against a queue-level reference model (in-flight list with per-entry kill flags).
module tb_if_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_busy_o;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    if_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .jump_addr_i  (jump_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_addr_o  (inst_addr_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .fetch_busy_o (fetch_busy_o)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct { logic [31:0] addr; bit killed; } fl_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } iw_t;
    fl_t         inflight[$];
    iw_t         iq[$];
    logic [31:0] m_pc;
    logic [31:0] m_bub;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ia;
        logic [31:0] e_inst;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    function automatic bit credit();
        return (inflight.size() + iq.size()) < DEPTH;
    endfunction

    function automatic logic m_req();
        return rst_i && !flush_i && credit();
    endfunction

    task automatic model_clear();
        inflight.delete();
        iq.delete();
        m_pc  = RST_PC;
        m_bub = '0;
    endtask

    task automatic check_model();
        logic        e_v;
        logic [31:0] e_inst;
        logic [31:0] e_ia;
        e_v    = iq.size() != 0;
        e_inst = e_v ? iq[0].data : NOP_WORD;
        e_ia   = e_v ? iq[0].addr : 32'h0;
        check("req", 32'(ibus_req_o), 32'(m_req()));
        check("ibus_addr", ibus_addr_o, m_pc);
        check("inst_valid", 32'(inst_valid_o), 32'(e_v));
        check("inst", inst_o, e_inst);
        check("inst_addr", inst_addr_o, e_ia);
        check("fetch_busy", 32'(fetch_busy_o), 32'(!e_v));
`ifdef IFETCH_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt_o, m_bub);
`endif
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit  resp, grant, pop;
        fl_t e;
        iw_t w;
        resp  = ibus_rvalid_i && inflight.size() > 0;
        grant = m_req() && ibus_gnt_i;
        pop   = iq.size() != 0 && !stall_i && !flush_i;
        if (iq.size() == 0 && !stall_i && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
        if (pop) void'(iq.pop_front());
        if (resp) begin
            e = inflight.pop_front();
            if (!e.killed && !flush_i) begin
                w.addr = e.addr;
                w.data = ibus_rdata_i;
                iq.push_back(w);
            end
        end
        if (flush_i) begin
            iq.delete();
            foreach (inflight[k]) inflight[k].killed = 1'b1;
            m_pc = {jump_addr_i[31:2], 2'b00};
        end else if (grant) begin
            e.addr   = m_pc;
            e.killed = 1'b0;
            inflight.push_back(e);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // The bus answers the oldest in-flight request with rdata = addr ^ KEY.
    task automatic drive(input logic st, input logic fl, input logic [31:0] ja,
                         input logic g, input logic rv);
        stall_i     = st;
        flush_i     = fl;
        jump_addr_i = ja;
        ibus_gnt_i  = g;
        if (rv && inflight.size() > 0) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = inflight[0].addr ^ KEY;
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
        end
    endtask

    // Assert reset between edges, check outputs immediately, release after the next edge.
    task automatic do_reset();
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_req", 32'(ibus_req_o), 32'h0);
        check("rst_valid", 32'(inst_valid_o), 32'h0);
        check("rst_inst", inst_o, NOP_WORD);
        check("rst_inst_addr", inst_addr_o, 32'h0);
        check("rst_busy", 32'(fetch_busy_o), 32'h1);
        check("rst_ibus_addr", ibus_addr_o, RST_PC);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_bubble", bubble_cnt_o, 32'h0);
`endif
        model_clear();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    // Run a normal bus after a redirect; the first request and first valid instruction must be at target.
    task automatic run_to_target(input logic [31:0] target, input string tag);
        bit seen_req, done;
        seen_req = 1'b0;
        done     = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            if (!seen_req && ibus_req_o) begin
                seen_req = 1'b1;
                check({tag, "_req_addr"}, ibus_addr_o, target);
            end
            if (inst_valid_o) begin
                check({tag, "_first_inst_addr"}, inst_addr_o, target);
                check({tag, "_first_inst"}, inst_o, target ^ KEY);
                done = 1'b1;
            end
            cycle();
        end
        if (!done) timeout({tag, "_first_inst"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hit;
        logic [31:0] held_addr;
        logic [31:0] held_inst;

        // Zero-wait bus from reset release: gnt always high, response one cycle after grant.
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h00, 1'b0, 32'h0, NOP_WORD};
        tbl[1] = '{1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 32'h04, 1'b0, 32'h0, NOP_WORD};
        tbl[2] = '{1'b1, 1'b1, 32'hA5A5_0004, 1'b0, 32'h08, 1'b1, 32'h0, 32'hA5A5_0000};
        tbl[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h08, 1'b1, 32'h4, 32'hA5A5_0004};
        tbl[4] = '{1'b1, 1'b1, 32'hA5A5_0008, 1'b1, 32'h0C, 1'b0, 32'h0, NOP_WORD};
        tbl[5] = '{1'b1, 1'b1, 32'hA5A5_000C, 1'b0, 32'h10, 1'b1, 32'h8, 32'hA5A5_0008};
        tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'hC, 32'hA5A5_000C};
        tbl[7] = '{1'b1, 1'b1, 32'hA5A5_0010, 1'b1, 32'h14, 1'b0, 32'h0, NOP_WORD};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            stall_i       = 1'b0;
            flush_i       = 1'b0;
            ibus_gnt_i    = tbl[i].gnt;
            ibus_rvalid_i = tbl[i].rv;
            ibus_rdata_i  = tbl[i].rdata;
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), 32'(ibus_req_o), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_addr", i), ibus_addr_o, tbl[i].e_addr);
            check($sformatf("tbl%0d_valid", i), 32'(inst_valid_o), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_inst_addr", i), inst_addr_o, tbl[i].e_ia);
            check($sformatf("tbl%0d_inst", i), inst_o, tbl[i].e_inst);
            check_model();
            model_step();
            @(posedge clk);
            #1;
        end

        // Grant withheld for 3 cycles while requesting pc 0x8.
        do_reset();
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (m_pc == 32'h8 && credit()) hit = 1'b1;
            else begin
                drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
                cycle();
            end
        end
        if (!hit) timeout("gnt_hold_setup");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            check("gnt_hold_req", 32'(ibus_req_o), 32'h1);
            check("gnt_hold_addr", ibus_addr_o, 32'h8);
            if (k == 2) begin
                check("gnt_hold_inst", inst_o, NOP_WORD);
                check("gnt_hold_busy", 32'(fetch_busy_o), 32'h1);
            end
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            cycle();
        end

        // Stall with a full queue: outputs hold and no credit remains.
        do_reset();
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (iq.size() == DEPTH) hit = 1'b1;
            else begin
                drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
                cycle();
            end
        end
        if (!hit) timeout("stall_fill");
        held_addr = inst_addr_o;
        held_inst = inst_o;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            check("stall_req", 32'(ibus_req_o), 32'h0);
            check("stall_hold_addr", inst_addr_o, held_addr);
            check("stall_hold_inst", inst_o, held_inst);
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            cycle();
        end

        // Flush to 0x103 with two requests outstanding.
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h103, 1'b1, 1'b0);
        #1;
        check("flush_req_low", 32'(ibus_req_o), 32'h0);
        cycle();
        run_to_target(32'h100, "flush2");

        // Flush in the same cycle as the only outstanding response.
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        cycle();
        run_to_target(32'h200, "flush_rv");

        // Random traffic with protocol-error rvalids and a mid-stream async reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom,
                  ($urandom % 10) < 7, ($urandom % 10) < 6);
            if (inflight.size() == 0 && ($urandom % 30) == 0) ibus_rvalid_i = 1'b1;
            if (c == 1500) begin
                do_reset();
                drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
                #1;
                check("rst_restart_req", 32'(ibus_req_o), 32'h1);
                check("rst_restart_addr", ibus_addr_o, RST_PC);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
